// File: rtl/seg7_driver_pkg.sv
// Shared types and glyph table for the multi-digit 7-segment display driver.
package seg7_driver_pkg;

  // Active-low segments: bit 7 = dp, bits 6:0 = g..a
  typedef logic [7:0] seg7p_t;

  typedef enum logic [1:0] {
    OFF    = 2'd0,
    STATIC = 2'd1,
    BLINK  = 2'd2,
    SCROLL = 2'd3
  } disp_mode_t;

  localparam seg7p_t SEG7_BLANK = 8'hFF;

  // Hex glyphs 0-F with the decimal point dark
  localparam seg7p_t SEG7_GLYPH [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

endpackage

// File: rtl/seg7_driver_decode.sv
// Single-digit decoder: nibble plus dp to active-low segments, with blanking.
module seg7_decode
  import seg7_driver_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  input  logic       blank,
  output seg7p_t     seg
);

  // A blanked digit still shows its decimal point when requested
  always_comb begin
    seg    = blank ? SEG7_BLANK : SEG7_GLYPH[nibble];
    seg[7] = ~dp;
  end

endmodule

// File: rtl/seg7_driver.sv
// Multi-digit 7-segment driver with off/static/blink/scroll modes and
// leading-zero blanking; segment outputs are registered.
module seg7_driver
  import seg7_driver_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int CLK_HZ     = 50_000_000,
  parameter int BLINK_HZ   = 2,
  parameter int SCROLL_HZ  = 4
) (
  input  logic                    clk,
  input  logic                    rst_,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  disp_mode_t              mode,
  input  logic                    lzb,
  input  logic                    load_valid,
  output logic                    load_ready,
  output seg7p_t [NUM_DIGITS-1:0] hex_
);

  localparam int BH = CLK_HZ / (2 * BLINK_HZ);
  localparam int SP = CLK_HZ / SCROLL_HZ;
  localparam int BW = (BH > 1) ? $clog2(BH) : 1;
  localparam int SW = (SP > 1) ? $clog2(SP) : 1;
  localparam int PW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [BW-1:0] BTC = BW'(BH - 1);
  localparam logic [SW-1:0] STC = SW'(SP - 1);
  localparam logic [PW-1:0] PTC = PW'(NUM_DIGITS - 1);

  disp_mode_t              mode_q, mode_d;
  logic [4*NUM_DIGITS-1:0] value_q, value_d;
  logic [NUM_DIGITS-1:0]   dp_q, dp_d;
  logic                    lzb_q, lzb_d;
  logic [BW-1:0]           bpre_q, bpre_d;
  logic [SW-1:0]           spre_q, spre_d;
  logic [PW-1:0]           pos_q, pos_d;
  logic                    phase_on_q, phase_on_d;
  seg7p_t [NUM_DIGITS-1:0] hex_q, hex_d;

  logic load_acc;

  assign load_ready = (mode_q != SCROLL) || ((pos_q == '0) && (spre_q == STC));
  assign load_acc   = load_valid && load_ready;
  assign hex_       = hex_q;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      mode_q     <= OFF;
      value_q    <= '0;
      dp_q       <= '0;
      lzb_q      <= 1'b0;
      bpre_q     <= '0;
      spre_q     <= '0;
      pos_q      <= '0;
      phase_on_q <= 1'b1;
      hex_q      <= '1;
    end else begin
      mode_q     <= mode_d;
      value_q    <= value_d;
      dp_q       <= dp_d;
      lzb_q      <= lzb_d;
      bpre_q     <= bpre_d;
      spre_q     <= spre_d;
      pos_q      <= pos_d;
      phase_on_q <= phase_on_d;
      hex_q      <= hex_d;
    end
  end

  // Only the active mode's prescaler runs; a load restarts the animation
  always_comb begin
    mode_d     = mode_q;
    value_d    = value_q;
    dp_d       = dp_q;
    lzb_d      = lzb_q;
    bpre_d     = '0;
    spre_d     = '0;
    pos_d      = pos_q;
    phase_on_d = phase_on_q;
    case (mode_q)
      BLINK: begin
        if (bpre_q == BTC) begin
          phase_on_d = ~phase_on_q;
        end else begin
          bpre_d = bpre_q + BW'(1);
        end
      end
      SCROLL: begin
        if (spre_q == STC) begin
          pos_d = (pos_q == PTC) ? '0 : pos_q + PW'(1);
        end else begin
          spre_d = spre_q + SW'(1);
        end
      end
      default: ;
    endcase
    if (load_acc) begin
      mode_d     = mode;
      value_d    = value;
      dp_d       = dp;
      lzb_d      = lzb;
      bpre_d     = '0;
      spre_d     = '0;
      pos_d      = '0;
      phase_on_d = 1'b1;
    end
  end

  logic [3:0] nib    [NUM_DIGITS];
  logic       blank_raw [NUM_DIGITS];
  logic [3:0] dnib   [NUM_DIGITS];
  logic       ddp    [NUM_DIGITS];
  logic       dblank [NUM_DIGITS];
  seg7p_t     dec_seg [NUM_DIGITS];
  logic       seen;
  logic       show;

  // Blanking is decided on the unrotated vector, then rotated with it
  always_comb begin
    seen = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      nib[i]       = value_q[4*i +: 4];
      blank_raw[i] = 1'b0;
    end
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      seen         = seen | (nib[i] != 4'h0);
      blank_raw[i] = lzb_q & ~seen;
    end
    for (int i = 0; i < NUM_DIGITS; i++) begin
      dnib[i]   = nib[i];
      ddp[i]    = dp_q[i];
      dblank[i] = blank_raw[i];
    end
    for (int p = 1; p < NUM_DIGITS; p++) begin
      if (pos_q == PW'(p)) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          dnib[i]   = nib[(i - p + NUM_DIGITS) % NUM_DIGITS];
          ddp[i]    = dp_q[(i - p + NUM_DIGITS) % NUM_DIGITS];
          dblank[i] = blank_raw[(i - p + NUM_DIGITS) % NUM_DIGITS];
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
    seg7_decode u_dec (
      .nibble (dnib[g]),
      .dp     (ddp[g]),
      .blank  (dblank[g]),
      .seg    (dec_seg[g])
    );
  end

  always_comb begin
    show = (mode_q == STATIC) || (mode_q == SCROLL) ||
           ((mode_q == BLINK) && phase_on_q);
    for (int i = 0; i < NUM_DIGITS; i++) begin
      hex_d[i] = show ? dec_seg[i] : SEG7_BLANK;
    end
  end

endmodule

// File: tb/tb_seg7_driver.sv
// Scoreboard bench for seg7_driver: stimulus queues cycle-tagged expectations,
// a negedge monitor pops and compares them against hex_ and load_ready.
module tb_seg7_driver;
  import seg7_driver_pkg::*;

  logic         clk = 1'b0;
  logic         rst_;
  logic [15:0]  value;
  logic [3:0]   dp;
  disp_mode_t   mode;
  logic         lzb;
  logic         load_valid;
  logic         load_ready;
  seg7p_t [3:0] hex_;

  always #5 clk = ~clk;

  seg7_driver #(
    .NUM_DIGITS (4),
    .CLK_HZ     (16),
    .BLINK_HZ   (2),
    .SCROLL_HZ  (4)
  ) dut (
    .clk        (clk),
    .rst_       (rst_),
    .value      (value),
    .dp         (dp),
    .mode       (mode),
    .lzb        (lzb),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .hex_       (hex_)
  );

  // Active-high gfedcba codes for 0-F
  localparam logic [6:0] AH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef struct {
    int          cyc;
    logic [31:0] hex;
    logic        rdy;
    bit          chk_rdy;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   compared = 0;
  int   mism = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Digit value -1 means blank; dp bits apply regardless
  function automatic logic [31:0] img(int d3, int d2, int d1, int d0, logic [3:0] dpv);
    int d [4];
    logic [7:0]  b;
    logic [31:0] r;
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      b = (d[i] < 0) ? 8'hFF : {1'b1, ~AH[d[i]]};
      b[7] = ~dpv[i];
      r[8*i +: 8] = b;
    end
    return r;
  endfunction

  function automatic void expect_at(int c, logic [31:0] h, logic r, bit cr, string n);
    exp_t e;
    e.cyc = c; e.hex = h; e.rdy = r; e.chk_rdy = cr; e.name = n;
    sb.push_back(e);
  endfunction

  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      compared++;
      if (e.cyc != cyc) begin
        mism++;
        $display("FAIL %s stale expectation for cyc %0d seen at cyc %0d", e.name, e.cyc, cyc);
      end else if (hex_ !== e.hex || (e.chk_rdy && load_ready !== e.rdy)) begin
        mism++;
        $display("FAIL %s cyc=%0d got hex_=%h ready=%b, expected hex_=%h ready=%b",
                 e.name, cyc, hex_, load_ready, e.hex, e.rdy);
      end
    end
  end

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic load(input disp_mode_t m, input logic [15:0] v, input logic [3:0] d,
                      input logic z, output int acc);
    @(negedge clk);
    mode = m; value = v; dp = d; lzb = z; load_valid = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
    acc = cyc;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int a, b, c;
    logic [31:0] scr [5];
    rst_ = 1'b0; value = '0; dp = '0; mode = OFF; lzb = 1'b0; load_valid = 1'b0;
    expect_at(1, 32'hFFFF_FFFF, 1'b1, 1, "reset");
    expect_at(2, 32'hFFFF_FFFF, 1'b1, 1, "reset_rel");
    expect_at(3, 32'hFFFF_FFFF, 1'b1, 1, "off_idle");
    #12 rst_ = 1'b1;
    wait_cyc(3);

    load(STATIC, 16'h12AF, 4'b0100, 1'b0, a);
    for (int k = 1; k <= 4; k++) expect_at(a + k, img(1, 2, 10, 15, 4'b0100), 1'b1, 1, "static");
    value = 16'hFFFF; dp = 4'hF; mode = SCROLL; lzb = 1'b1;
    wait_cyc(a + 4);

    load(BLINK, 16'h0008, 4'b0000, 1'b0, a);
    for (int k = 0; k < 12; k++)
      expect_at(a + 1 + k, ((k / 4) % 2 == 0) ? img(0, 0, 0, 8, 4'b0000) : 32'hFFFF_FFFF,
                1'b1, 1, "blink");
    wait_cyc(a + 12);

    scr[0] = img(1, 2, 3, 4, 4'b0000);
    scr[1] = img(2, 3, 4, 1, 4'b0000);
    scr[2] = img(3, 4, 1, 2, 4'b0000);
    scr[3] = img(4, 1, 2, 3, 4'b0000);
    scr[4] = img(1, 2, 3, 4, 4'b0000);
    load(SCROLL, 16'h1234, 4'b0000, 1'b0, a);
    for (int k = 0; k < 20; k++)
      expect_at(a + 1 + k, scr[k / 4], (k == 2) || (k >= 18), 1, "scroll");
    wait_cyc(a + 4);
    mode = STATIC; value = 16'h0050; dp = 4'b0000; lzb = 1'b1; load_valid = 1'b1;
    wait_cyc(a + 20);
    load_valid = 1'b0;
    b = cyc;
    expect_at(b + 1, img(-1, -1, 5, 0, 4'b0000), 1'b1, 1, "lzb_0050");
    expect_at(b + 2, img(-1, -1, 5, 0, 4'b0000), 1'b1, 1, "lzb_0050_hold");

    load(STATIC, 16'h0000, 4'b0000, 1'b1, c);
    expect_at(c + 1, img(-1, -1, -1, 0, 4'b0000), 1'b1, 1, "lzb_zero");
    load(STATIC, 16'h0000, 4'b1000, 1'b1, c);
    expect_at(c + 1, img(-1, -1, -1, 0, 4'b1000), 1'b1, 1, "lzb_dp_kept");

    load(SCROLL, 16'h0050, 4'b0000, 1'b1, a);
    for (int k = 1; k <= 4; k++) expect_at(a + k, img(-1, -1, 5, 0, 4'b0000), 1'b0, 0, "scroll_lzb0");
    expect_at(a + 5, img(-1, 5, 0, -1, 4'b0000), 1'b0, 0, "scroll_lzb1");
    expect_at(a + 6, img(-1, 5, 0, -1, 4'b0000), 1'b0, 0, "scroll_lzb1");
    wait_cyc(a + 6);
    expect_at(a + 7, 32'hFFFF_FFFF, 1'b1, 1, "async_rst");
    expect_at(a + 8, 32'hFFFF_FFFF, 1'b1, 1, "off_after_rst");
    expect_at(a + 9, 32'hFFFF_FFFF, 1'b1, 1, "off_after_rst");
    @(posedge clk);
    #1 rst_ = 1'b0;
    @(negedge clk);
    #1 rst_ = 1'b1;
    wait_cyc(a + 9);

    load(BLINK, 16'h0008, 4'b0000, 1'b0, c);
    for (int k = 1; k <= 4; k++) expect_at(c + k, img(0, 0, 0, 8, 4'b0000), 1'b1, 1, "blink_after_rst");
    expect_at(c + 5, 32'hFFFF_FFFF, 1'b1, 1, "blink_after_rst_off");
    wait_cyc(c + 6);

    repeat (20) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    if (sb.size() != 0) begin
      compared++;
      mism++;
      $display("FAIL drain %0d expectations left, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end

endmodule
